// File: rtl/aes_pkg.sv
// AES-128 key schedule shared types and constants.
// Holds the FSM state type, round-key type and Rcon table.
package aes_pkg;

    localparam int NR = 10;

    typedef logic [127:0] rkey_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    // Rcon top bytes, entry i at bits [8*i +: 8]; entry 0 unused
    localparam logic [87:0] RCON = {
        8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10,
        8'h08, 8'h04, 8'h02, 8'h01, 8'h00
    };

    function automatic logic [7:0] rcon_of(input logic [3:0] i);
        rcon_of = (i > 4'd10) ? 8'h00 : RCON[8*int'(i) +: 8];
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box.
// Multiplicative inverse in GF(2^8) followed by the affine map.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);

    function automatic logic [7:0] xt(input logic [7:0] b);
        xt = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] x,
                                        input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ t;
            t = xt(t);
        end
        gmul = p;
    endfunction

    // x^254 == x^-1 (and maps 0 to 0)
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = x;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) r = gmul(r, p);
            p = gmul(p, p);
        end
        ginv = r;
    endfunction

    logic [7:0] b;

    // inverse then affine transform
    always_comb begin
        b = ginv(a);
        s = b
          ^ {b[6:0], b[7]}
          ^ {b[5:0], b[7:6]}
          ^ {b[4:0], b[7:5]}
          ^ {b[3:0], b[7:4]}
          ^ 8'h63;
    end

endmodule

// File: rtl/inv_key_sched.sv
// AES-128 key expansion, streaming round keys last-to-first.
// Expands one round key per cycle into a flop store, then replays 10..0.
module inv_key_sched
    import aes_pkg::*;
#(
    parameter int NR = aes_pkg::NR
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_idx,
    output logic         rk_last
);

    localparam logic [3:0] LAST_RND = 4'(NR);

    state_t     state;
    logic [3:0] rnd;
    logic [3:0] idx;
    rkey_t      ks [0:NR];

    rkey_t       prev_key;
    rkey_t       next_key;
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot, sub;
    logic [31:0] n0, n1, n2, n3;

    assign prev_key = ks[rnd - 4'd1];
    assign w0  = prev_key[127:96];
    assign w1  = prev_key[95:64];
    assign w2  = prev_key[63:32];
    assign w3  = prev_key[31:0];
    assign rot = {w3[23:0], w3[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sub
        aes_sbox u_sbox (
            .a (rot[8*g +: 8]),
            .s (sub[8*g +: 8])
        );
    end

    // one full round key from the previous one
    always_comb begin
        n0 = w0 ^ sub ^ {rcon_of(rnd), 24'h0};
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        next_key = {n0, n1, n2, n3};
    end

    // control FSM: round counter and stream index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            rnd   <= 4'd0;
            idx   <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_EXPAND;
                        rnd   <= 4'd1;
                    end
                end
                ST_EXPAND: begin
                    if (rnd == LAST_RND) begin
                        state <= ST_STREAM;
                        idx   <= LAST_RND;
                        rnd   <= 4'd0;
                    end else begin
                        rnd <= rnd + 4'd1;
                    end
                end
                ST_STREAM: begin
                    if (rk_ready) begin
                        if (idx == 4'd0) state <= ST_IDLE;
                        else             idx   <= idx - 4'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // key store: entry 0 on accept, entry rnd during expansion
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && start)
            ks[0] <= key_in;
        else if (state == ST_EXPAND)
            ks[rnd] <= next_key;
    end

    // outputs; store contents hidden unless streaming
    always_comb begin
        busy     = (state != ST_IDLE);
        rk_valid = (state == ST_STREAM);
        rk_data  = rk_valid ? ks[idx] : 128'h0;
        rk_idx   = idx;
        rk_last  = rk_valid && (idx == 4'd0);
    end

endmodule

// File: tb/tb_inv_key_sched.sv
// Bench for inv_key_sched: random keys against a word-level
// FIPS-197 key expansion model, plus the fixed reference vectors.
module tb_inv_key_sched;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [127:0] key_in = '0;
    logic         rk_ready = 1'b0;
    logic         busy, rk_valid, rk_last;
    logic [127:0] rk_data;
    logic [3:0]   rk_idx;

    int tests = 0;
    int fails = 0;

    logic [7:0]   sb [0:255];
    logic [127:0] exp_rk [0:10];

    logic [3:0]   q_idx [$];
    logic [127:0] q_data [$];
    bit           q_last [$];
    bit           stable_ok;
    bit           timed_out;

    localparam logic [127:0] K1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K1R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K1R1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K0R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    inv_key_sched #(.NR(10)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key_in   (key_in),
        .busy     (busy),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_data  (rk_data),
        .rk_idx   (rk_idx),
        .rk_last  (rk_last)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    function automatic int rotl8(input int v, input int n);
        return ((v << n) | (v >> (8 - n))) & 'hff;
    endfunction

    // S-box table built by the p/q generator walk
    task automatic build_sbox();
        int p, q, x;
        p = 1;
        q = 1;
        sb[0] = 8'h63;
        do begin
            p = (p ^ (p << 1) ^ (((p & 'h80) != 0) ? 'h1b : 0)) & 'hff;
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            q = q & 'hff;
            if ((q & 'h80) != 0) q = q ^ 'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sb[p] = 8'(x ^ 'h63);
        end while (p != 1);
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    // word-array key expansion, 44 words
    task automatic model(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++)
            exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic do_start(input logic [127:0] k);
        key_in = k;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        key_in = rand_key();
    endtask

    // records transfers; stops on last transfer or at stop_idx
    task automatic collect(input int stall_at, input int stall_len,
                           input bit rnd_ready, input int stop_idx,
                           input bit start_on_last,
                           input logic [127:0] k2);
        int           stall_cnt;
        bit           held, done, r;
        logic [127:0] h_data;
        logic [3:0]   h_idx;
        stall_cnt = 0;
        held = 0;
        done = 0;
        h_data = '0;
        h_idx = '0;
        q_idx.delete();
        q_data.delete();
        q_last.delete();
        stable_ok = 1;
        timed_out = 1;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            if (held && (rk_valid !== 1'b1 || rk_data !== h_data
                         || rk_idx !== h_idx))
                stable_ok = 0;
            held = 0;
            if (rk_valid === 1'b1 && stop_idx >= 0
                && int'(rk_idx) == stop_idx) begin
                rk_ready = 1'b0;
                timed_out = 0;
                done = 1;
            end else if (rk_valid === 1'b1) begin
                if (int'(rk_idx) == stall_at && stall_cnt < stall_len) begin
                    r = 0;
                    stall_cnt++;
                end else if (rnd_ready) begin
                    r = 1'($urandom_range(0, 1));
                end else begin
                    r = 1;
                end
                rk_ready = r;
                if (r) begin
                    q_idx.push_back(rk_idx);
                    q_data.push_back(rk_data);
                    q_last.push_back(rk_last === 1'b1);
                    if (rk_last === 1'b1) begin
                        done = 1;
                        timed_out = 0;
                        if (start_on_last) begin
                            start = 1'b1;
                            key_in = k2;
                        end
                    end
                end else begin
                    held = 1;
                    h_data = rk_data;
                    h_idx = rk_idx;
                end
            end else begin
                rk_ready = 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        tests++;
        if ({busy, rk_valid, rk_last, rk_idx, rk_data} !== '0) begin
            fails++;
            $display("FAIL reset_outputs got busy=%b v=%b last=%b idx=%0d data=%h, expected all 0",
                     busy, rk_valid, rk_last, rk_idx, rk_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_vector();
        int first;
        model(K1);
        rk_ready = 1'b1;
        do_start(K1);
        first = -1;
        for (int k = 1; k <= 30 && first < 0; k++) begin
            @(negedge clk);
            if (rk_valid === 1'b1) first = k;
        end
        // valid in the 11th cycle following the accepting edge
        tests++;
        if (first != 10) begin
            fails++;
            $display("FAIL latency got %0d edges, expected 10", first);
        end
        tests++;
        if (rk_idx !== 4'd10 || rk_data !== K1R10) begin
            fails++;
            $display("FAIL first_key got idx=%0d data=%h, expected idx=10 data=%h",
                     rk_idx, rk_data, K1R10);
        end
        rk_ready = 1'b0;
        collect(-1, 0, 0, -1, 0, '0);
        tests++;
        if (timed_out || q_idx.size() != 11) begin
            fails++;
            $display("FAIL vec_count got %0d transfers, expected 11", q_idx.size());
        end
        for (int i = 0; i < q_idx.size() && i < 11; i++) begin
            tests++;
            if (q_idx[i] !== 4'(10 - i) || q_data[i] !== exp_rk[10 - i]
                || q_last[i] !== (i == 10)) begin
                fails++;
                $display("FAIL vec_seq[%0d] got idx=%0d data=%h last=%b, expected idx=%0d data=%h",
                         i, q_idx[i], q_data[i], q_last[i], 10 - i, exp_rk[10 - i]);
            end
        end
        if (q_idx.size() == 11) begin
            tests++;
            if (q_data[9] !== K1R1 || q_data[10] !== K1 || !q_last[10]) begin
                fails++;
                $display("FAIL vec_r1_r0 got r1=%h r0=%h last=%b, expected r1=%h r0=%h last=1",
                         q_data[9], q_data[10], q_last[10], K1R1, K1);
            end
        end
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || rk_valid !== 1'b0 || rk_data !== '0) begin
            fails++;
            $display("FAIL vec_idle got busy=%b v=%b data=%h, expected 0",
                     busy, rk_valid, rk_data);
        end
    endtask

    task automatic test_stall();
        model(K1);
        do_start(K1);
        collect(7, 5, 0, -1, 0, '0);
        tests++;
        if (!stable_ok) begin
            fails++;
            $display("FAIL stall_hold got unstable outputs, expected held");
        end
        tests++;
        if (timed_out || q_idx.size() != 11) begin
            fails++;
            $display("FAIL stall_count got %0d transfers, expected 11", q_idx.size());
        end
        for (int i = 0; i < q_idx.size() && i < 11; i++) begin
            tests++;
            if (q_idx[i] !== 4'(10 - i) || q_data[i] !== exp_rk[10 - i]
                || q_last[i] !== (i == 10)) begin
                fails++;
                $display("FAIL stall_seq[%0d] got idx=%0d data=%h, expected idx=%0d data=%h",
                         i, q_idx[i], q_data[i], 10 - i, exp_rk[10 - i]);
            end
        end
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || rk_valid !== 1'b0) begin
            fails++;
            $display("FAIL stall_idle got busy=%b v=%b, expected 0", busy, rk_valid);
        end
    endtask

    task automatic test_zero_key();
        model('0);
        do_start('0);
        repeat (3) @(negedge clk);
        start = 1'b1;
        key_in = rand_key();
        @(negedge clk);
        start = 1'b0;
        tests++;
        if (busy !== 1'b1 || rk_valid !== 1'b0 || rk_data !== '0) begin
            fails++;
            $display("FAIL zero_expand got busy=%b v=%b data=%h, expected busy=1 v=0 data=0",
                     busy, rk_valid, rk_data);
        end
        collect(-1, 0, 0, -1, 0, '0);
        tests++;
        if (timed_out || q_idx.size() != 11) begin
            fails++;
            $display("FAIL zero_count got %0d transfers, expected 11", q_idx.size());
        end
        for (int i = 0; i < q_idx.size() && i < 11; i++) begin
            tests++;
            if (q_idx[i] !== 4'(10 - i) || q_data[i] !== exp_rk[10 - i]
                || q_last[i] !== (i == 10)) begin
                fails++;
                $display("FAIL zero_seq[%0d] got idx=%0d data=%h, expected idx=%0d data=%h",
                         i, q_idx[i], q_data[i], 10 - i, exp_rk[10 - i]);
            end
        end
        if (q_idx.size() > 0) begin
            tests++;
            if (q_data[0] !== K0R10) begin
                fails++;
                $display("FAIL zero_r10 got %h, expected %h", q_data[0], K0R10);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        logic [127:0] k;
        do_start(rand_key());
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({busy, rk_valid, rk_last, rk_idx, rk_data} !== '0) begin
            fails++;
            $display("FAIL abort_expand got busy=%b v=%b idx=%0d data=%h, expected 0",
                     busy, rk_valid, rk_idx, rk_data);
        end
        @(negedge clk);
        rst = 1'b0;
        k = rand_key();
        model(k);
        do_start(k);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL abort_accept got busy=%b, expected 1", busy);
        end
        collect(-1, 0, 0, 5, 0, '0);
        tests++;
        if (timed_out || rk_idx !== 4'd5) begin
            fails++;
            $display("FAIL abort_reach5 got idx=%0d, expected 5", rk_idx);
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({busy, rk_valid, rk_last, rk_idx, rk_data} !== '0) begin
            fails++;
            $display("FAIL abort_stream got busy=%b v=%b idx=%0d data=%h, expected 0",
                     busy, rk_valid, rk_idx, rk_data);
        end
        @(negedge clk);
        rst = 1'b0;
        k = rand_key();
        model(k);
        do_start(k);
        collect(-1, 0, 1, -1, 0, '0);
        tests++;
        if (timed_out || q_idx.size() != 11) begin
            fails++;
            $display("FAIL abort_count got %0d transfers, expected 11", q_idx.size());
        end
        for (int i = 0; i < q_idx.size() && i < 11; i++) begin
            tests++;
            if (q_idx[i] !== 4'(10 - i) || q_data[i] !== exp_rk[10 - i]
                || q_last[i] !== (i == 10)) begin
                fails++;
                $display("FAIL abort_seq[%0d] got idx=%0d data=%h, expected idx=%0d data=%h",
                         i, q_idx[i], q_data[i], 10 - i, exp_rk[10 - i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [127:0] ka, kb;
        ka = rand_key();
        kb = rand_key();
        model(ka);
        do_start(ka);
        collect(-1, 0, 0, -1, 1, kb);
        tests++;
        if (timed_out || q_idx.size() != 11) begin
            fails++;
            $display("FAIL b2b_first_count got %0d transfers, expected 11", q_idx.size());
        end
        for (int i = 0; i < q_idx.size() && i < 11; i++) begin
            tests++;
            if (q_idx[i] !== 4'(10 - i) || q_data[i] !== exp_rk[10 - i]) begin
                fails++;
                $display("FAIL b2b_first_seq[%0d] got idx=%0d data=%h, expected idx=%0d data=%h",
                         i, q_idx[i], q_data[i], 10 - i, exp_rk[10 - i]);
            end
        end
        @(negedge clk);
        start = 1'b0;
        tests++;
        if (busy !== 1'b0 || rk_valid !== 1'b0) begin
            fails++;
            $display("FAIL b2b_ignored got busy=%b v=%b, expected 0", busy, rk_valid);
        end
        model(kb);
        do_start(kb);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL b2b_accept got busy=%b, expected 1", busy);
        end
        collect(-1, 0, 0, -1, 0, '0);
        tests++;
        if (timed_out || q_idx.size() != 11) begin
            fails++;
            $display("FAIL b2b_second_count got %0d transfers, expected 11", q_idx.size());
        end
        for (int i = 0; i < q_idx.size() && i < 11; i++) begin
            tests++;
            if (q_idx[i] !== 4'(10 - i) || q_data[i] !== exp_rk[10 - i]
                || q_last[i] !== (i == 10)) begin
                fails++;
                $display("FAIL b2b_second_seq[%0d] got idx=%0d data=%h, expected idx=%0d data=%h",
                         i, q_idx[i], q_data[i], 10 - i, exp_rk[10 - i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [127:0] k;
        for (int n = 0; n < 4; n++) begin
            k = rand_key();
            model(k);
            do_start(k);
            collect(-1, 0, 1, -1, 0, '0);
            tests++;
            if (timed_out || q_idx.size() != 11) begin
                fails++;
                $display("FAIL rand%0d_count got %0d transfers, expected 11",
                         n, q_idx.size());
            end
            for (int i = 0; i < q_idx.size() && i < 11; i++) begin
                tests++;
                if (q_idx[i] !== 4'(10 - i) || q_data[i] !== exp_rk[10 - i]
                    || q_last[i] !== (i == 10)) begin
                    fails++;
                    $display("FAIL rand%0d_seq[%0d] got idx=%0d data=%h, expected idx=%0d data=%h",
                             n, i, q_idx[i], q_data[i], 10 - i, exp_rk[10 - i]);
                end
            end
            @(negedge clk);
            tests++;
            if (busy !== 1'b0 || rk_valid !== 1'b0 || rk_data !== '0) begin
                fails++;
                $display("FAIL rand%0d_idle got busy=%b v=%b data=%h, expected 0",
                         n, busy, rk_valid, rk_data);
            end
        end
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_vector();
        test_stall();
        test_zero_key();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/inv_key_sched.md
INV_KEY_SCHED -- requirements
Module: inv_key_sched

Interface
REQ-001 SHALL have parameter NR, default 10, meaning number of AES-128 rounds; only 10 is supported.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port start  input  1  single-cycle request to expand key_in; sampled only in IDLE.
REQ-005 SHALL have port key_in  input  128  cipher key, byte 0 in bits [127:120], captured on an accepted start.
REQ-006 SHALL have port busy  output  1  high in every state other than IDLE.
REQ-007 SHALL have port rk_valid  output  1  round-key output valid.
REQ-008 SHALL have port rk_ready  input  1  downstream (AddRoundKey stage) accepts rk_data.
REQ-009 SHALL have port rk_data  output  128  current round key, same byte order as key_in.
REQ-010 SHALL have port rk_idx  output  4  round number of rk_data, 10 down to 0.
REQ-011 SHALL have port rk_last  output  1  high with rk_valid when rk_idx = 0.

Function
REQ-012 SHALL implement FSM states IDLE, EXPAND, STREAM.
REQ-013 IDLE -> EXPAND on start=1; key_in SHALL be written to key store entry 0 and the round counter SHALL be set to 1 in that edge.
REQ-014 EXPAND SHALL produce one full round key per cycle: w[4i] = w[4i-4] xor SubWord(RotWord(w[4i-1])) xor Rcon[i]; remaining three words by chained xor; all in one cycle.
REQ-015 Rcon[1..10] SHALL be 01,02,04,08,10,20,40,80,1B,36 in the top byte, remaining bytes zero.
REQ-016 Round key i SHALL be written to key store entry i; EXPAND SHALL last exactly 10 cycles (i = 1..10), then go to STREAM with read index 10.
REQ-017 In STREAM rk_valid SHALL be 1 and rk_data SHALL be key store entry rk_idx (registered store, combinational read).
REQ-018 A transfer SHALL occur on a cycle with rk_valid & rk_ready; the index then decrements by one.
REQ-019 With rk_ready low, rk_data, rk_idx and rk_valid SHALL hold unchanged.
REQ-020 Transfer at rk_idx = 0 SHALL return the FSM to IDLE; rk_valid SHALL be 0 the next cycle.
REQ-021 Latency: the first rk_valid SHALL appear 11 cycles after the edge accepting start.
REQ-022 start while busy SHALL be ignored, with no effect on state or stored keys.
REQ-023 start in the same cycle as the final transfer SHALL be ignored; a new start SHALL be accepted only in IDLE.
REQ-024 rk_valid SHALL be 0 in IDLE and EXPAND; rk_data SHALL be 0 whenever rk_valid is 0.

Reset
REQ-025 rst=1 SHALL asynchronously force state IDLE, busy=0, rk_valid=0, rk_data=0, rk_idx=0, rk_last=0, and the round counter to 0.
REQ-026 Key store contents need not be reset; no output SHALL expose them while rk_valid=0.
REQ-027 Reset asserted mid-EXPAND or mid-STREAM SHALL abort the operation; after release the block SHALL be in IDLE and SHALL accept start on the first clock edge.

Structure
REQ-028 Package aes_pkg SHALL hold the state enum type, the RCON table, the NR constant and the 128-bit round-key typedef.
REQ-029 One sub-module aes_sbox (combinational 8-bit forward S-box) SHALL be instantiated four times for SubWord; no other sub-modules.
REQ-030 The key store SHALL be 11 x 128 flops, written one entry per cycle, with no RAM macro.

Verification
REQ-031 key_in=2b7e151628aed2a6abf7158809cf4f3c, start, rk_ready=1 -> 11 cycles later rk_idx=10, rk_data=d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-032 Same key, continuous ready -> rk_idx=1 gives a0fafe1788542cb123a339392a6c7605; rk_idx=0 gives the key itself with rk_last=1; then IDLE and busy=0.
REQ-033 Same key, rk_ready low for 5 cycles at rk_idx=7 -> outputs are stable throughout, no skipped or repeated index, 11 transfers total.
REQ-034 Key all zeros -> rk_idx=10 gives b4ef5bcb3e92e21123e951cf6f8f188e; start pulsed during EXPAND -> no restart and same results.
REQ-035 rst pulsed at EXPAND cycle 4 and again at STREAM rk_idx=5 -> all outputs are 0 immediately; a new start after release streams correct keys from 10.
REQ-036 Back-to-back: start asserted on the rk_last transfer cycle is ignored; start one cycle later is accepted -> second key expands correctly.
